cargador_baterias: RTL and testbench

CARGADOR_BATERIAS -- requirements
Module: cargador_baterias

---
 rtl/cargador_baterias.sv | 143 ++++++++++++++
 tb/tb_cargador_baterias.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cargador_baterias.sv
// Two-battery charger: prescaled charge steps, load draw, one-hot level.
// In: clk rst en_carga tick consumo. Out: A B Sum nivel cargando agotado.
module cargador_baterias #(
  parameter int         PASO_TICKS = 4,
  parameter logic [3:0] A_INI      = 4'd0,
  parameter logic [3:0] B_INI      = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_carga,
  input  logic       tick,
  input  logic       consumo,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic [4:0] Sum,
  output logic [4:0] nivel,
  output logic       cargando,
  output logic       agotado
);

  typedef enum logic [1:0] {
    REPOSO,
    CARGA_A,
    CARGA_B,
    LLENO
  } estado_t;

  localparam logic [3:0] PASO_MAX = 4'(PASO_TICKS - 1);
  localparam logic [4:0] SUM_INI  = {1'b0, A_INI} + {1'b0, B_INI};

  function automatic logic [4:0] nivel_de(input logic [4:0] s);
    logic [4:0] n;
    n = 5'b10000;
    unique case (1'b1)
      (s <= 5'd5):                 n = 5'b00001;
      (s >= 5'd6  && s <= 5'd11):  n = 5'b00010;
      (s >= 5'd12 && s <= 5'd17):  n = 5'b00100;
      (s >= 5'd18 && s <= 5'd23):  n = 5'b01000;
      default:                     n = 5'b10000;
    endcase
    return n;
  endfunction

  estado_t    estado;
  estado_t    estado_nx;
  estado_t    destino;
  logic [3:0] presc;
  logic [3:0] presc_nx;
  logic [3:0] a_nx;
  logic [3:0] b_nx;
  logic [4:0] sum_nx;
  logic       en_carg;
  logic       paso;
  logic       vacio;
  logic       cons_ok;
  logic       cons_a;
  logic       cons_b;
  logic       carga_a;
  logic       carga_b;

  always_comb begin
    en_carg = (estado == CARGA_A) || (estado == CARGA_B);
    paso    = en_carg && en_carga && tick && (presc == PASO_MAX);
    vacio   = (A == 4'd0) && (B == 4'd0);
    cons_ok = consumo && !vacio;
    // Draw from the fuller battery; a tie draws from B.
    cons_a  = cons_ok && (A > B);
    cons_b  = cons_ok && !(A > B);
    carga_a = paso && (estado == CARGA_A);
    carga_b = paso && (estado == CARGA_B);
  end

  // A step and a draw landing on the same battery cancel out.
  always_comb begin
    a_nx = A;
    b_nx = B;
    if (carga_a && !cons_a && A != 4'd15)
      a_nx = A + 4'd1;
    else if (cons_a && !carga_a)
      a_nx = A - 4'd1;
    if (carga_b && !cons_b && B != 4'd15)
      b_nx = B + 4'd1;
    else if (cons_b && !carga_b)
      b_nx = B - 4'd1;
    sum_nx = {1'b0, a_nx} + {1'b0, b_nx};
  end

  // Target selection always looks at the updated charges.
  always_comb begin
    destino   = (a_nx <= b_nx) ? CARGA_A : CARGA_B;
    estado_nx = estado;
    if (!en_carga) begin
      estado_nx = REPOSO;
    end else begin
      unique case (estado)
        REPOSO, LLENO: begin
          if (sum_nx < 5'd30)
            estado_nx = destino;
        end
        CARGA_A, CARGA_B: begin
          if (a_nx == 4'd15 && b_nx == 4'd15)
            estado_nx = LLENO;
          else
            estado_nx = destino;
        end
        default: estado_nx = REPOSO;
      endcase
    end
  end

  always_comb begin
    presc_nx = presc;
    if (!en_carg || estado_nx == REPOSO ||
        estado_nx == LLENO)
      presc_nx = 4'd0;
    else if (tick && en_carga)
      presc_nx = paso ? 4'd0 : presc + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado   <= REPOSO;
      presc    <= 4'd0;
      A        <= A_INI;
      B        <= B_INI;
      Sum      <= SUM_INI;
      nivel    <= nivel_de(SUM_INI);
      cargando <= 1'b0;
      agotado  <= 1'b0;
    end else begin
      estado   <= estado_nx;
      presc    <= presc_nx;
      A        <= a_nx;
      B        <= b_nx;
      Sum      <= sum_nx;
      nivel    <= nivel_de(sum_nx);
      cargando <= (estado_nx == CARGA_A) ||
                  (estado_nx == CARGA_B);
      agotado  <= consumo && vacio;
    end
  end

endmodule

// File: tb/tb_cargador_baterias.sv
// Scoreboard bench for cargador_baterias.
// Three instances (0/0, 3/5, 15/14 reset charges) share one stimulus.
module tb_cargador_baterias;

  localparam int P = 4;

  typedef enum int {M_IDLE, M_CHA, M_CHB, M_FULL} mst_e;

  typedef struct {
    int   a;
    int   b;
    int   pc;
    mst_e st;
    bit   ag;
  } mstate_t;

  typedef struct {
    mstate_t m[3];
  } snap_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en_carga = 1'b0;
  logic tick = 1'b0;
  logic consumo = 1'b0;

  logic [3:0] da[3];
  logic [3:0] db[3];
  logic [4:0] ds[3];
  logic [4:0] dn[3];
  logic       dc[3];
  logic       dg[3];

  int ai[3] = '{0, 3, 15};
  int bi[3] = '{0, 5, 14};

  mstate_t m[3];
  snap_t   q[$];
  snap_t   mon_s;
  int      n_chk = 0;
  int      n_fail = 0;
  int      cyc_n = 0;

  always #5 clk = ~clk;

  cargador_baterias #(.PASO_TICKS(P)) u0 (
    .clk(clk), .rst(rst), .en_carga(en_carga),
    .tick(tick), .consumo(consumo),
    .A(da[0]), .B(db[0]), .Sum(ds[0]), .nivel(dn[0]),
    .cargando(dc[0]), .agotado(dg[0])
  );

  cargador_baterias #(
    .PASO_TICKS(P), .A_INI(4'd3), .B_INI(4'd5)
  ) u1 (
    .clk(clk), .rst(rst), .en_carga(en_carga),
    .tick(tick), .consumo(consumo),
    .A(da[1]), .B(db[1]), .Sum(ds[1]), .nivel(dn[1]),
    .cargando(dc[1]), .agotado(dg[1])
  );

  cargador_baterias #(
    .PASO_TICKS(P), .A_INI(4'd15), .B_INI(4'd14)
  ) u2 (
    .clk(clk), .rst(rst), .en_carga(en_carga),
    .tick(tick), .consumo(consumo),
    .A(da[2]), .B(db[2]), .Sum(ds[2]), .nivel(dn[2]),
    .cargando(dc[2]), .agotado(dg[2])
  );

  // Level class: six units per band, top band absorbs 30.
  function automatic int nivel_ref(input int s);
    int idx;
    idx = s / 6;
    if (idx > 4) idx = 4;
    return 1 << idx;
  endfunction

  function automatic bit charging(input mst_e s);
    return (s == M_CHA) || (s == M_CHB);
  endfunction

  function automatic mstate_t mstep(
    input mstate_t s, input bit r, input bit e,
    input bit t, input bit c, input int a0, input int b0
  );
    mstate_t n;
    bit chg;
    bit stp;
    int tc;
    int td;
    n = s;
    if (r) begin
      n.a = a0; n.b = b0; n.pc = 0;
      n.st = M_IDLE; n.ag = 0;
      return n;
    end
    chg  = charging(s.st);
    stp  = chg && e && t && (s.pc + 1 == P);
    if (chg && e && t) n.pc = stp ? 0 : s.pc + 1;
    else               n.pc = chg ? s.pc : 0;
    n.ag = c && s.a == 0 && s.b == 0;
    tc = stp ? ((s.st == M_CHA) ? 1 : 2) : 0;
    td = (c && !n.ag) ? ((s.a > s.b) ? 1 : 2) : 0;
    if (tc != td) begin
      if (tc == 1 && n.a < 15) n.a = n.a + 1;
      if (tc == 2 && n.b < 15) n.b = n.b + 1;
      if (td == 1 && n.a > 0)  n.a = n.a - 1;
      if (td == 2 && n.b > 0)  n.b = n.b - 1;
    end
    if (!e) n.st = M_IDLE;
    else if (chg) begin
      if (n.a == 15 && n.b == 15) n.st = M_FULL;
      else n.st = (n.a <= n.b) ? M_CHA : M_CHB;
    end else if (n.a + n.b < 30)
      n.st = (n.a <= n.b) ? M_CHA : M_CHB;
    if (!charging(n.st)) n.pc = 0;
    return n;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d",
               nm, cyc_n, act, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit e,
                     input bit t, input bit c);
    snap_t s;
    @(negedge clk);
    rst = r; en_carga = e; tick = t; consumo = c;
    for (int i = 0; i < 3; i++)
      m[i] = mstep(m[i], r, e, t, c, ai[i], bi[i]);
    s.m = m;
    q.push_back(s);
  endtask

  task automatic settle;
    @(posedge clk);
    #2;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc_n++;
      if (q.size() > 0) begin
        mon_s = q.pop_front();
        for (int i = 0; i < 3; i++) begin
          chk($sformatf("u%0d.A", i), 32'(da[i]),
              32'(mon_s.m[i].a));
          chk($sformatf("u%0d.B", i), 32'(db[i]),
              32'(mon_s.m[i].b));
          chk($sformatf("u%0d.Sum", i), 32'(ds[i]),
              32'(mon_s.m[i].a + mon_s.m[i].b));
          chk($sformatf("u%0d.nivel", i), 32'(dn[i]),
              32'(nivel_ref(mon_s.m[i].a + mon_s.m[i].b)));
          chk($sformatf("u%0d.cargando", i), 32'(dc[i]),
              32'(charging(mon_s.m[i].st)));
          chk($sformatf("u%0d.agotado", i), 32'(dg[i]),
              32'(mon_s.m[i].ag));
        end
      end
    end
  end

  initial begin
    bit r, e, t, c;
    for (int i = 0; i < 3; i++) begin
      m[i].a = 0; m[i].b = 0; m[i].pc = 0;
      m[i].st = M_IDLE; m[i].ag = 0;
    end

    // Balanced charge from empty; 15/14 instance fills up.
    cyc(1, 0, 0, 0);
    settle;
    chk("rst_u1_A", 32'(da[1]), 32'd3);
    chk("rst_u2_Sum", 32'(ds[2]), 32'd29);
    cyc(0, 1, 0, 0);
    for (int k = 0; k < 8; k++) cyc(0, 1, 1, 0);
    settle;
    chk("chg_A", 32'(da[0]), 32'd1);
    chk("chg_B", 32'(db[0]), 32'd1);
    chk("chg_Sum", 32'(ds[0]), 32'd2);
    chk("chg_nivel", 32'(dn[0]), 32'b00001);
    chk("chg_cargando", 32'(dc[0]), 32'd1);
    chk("full_B", 32'(db[2]), 32'd15);
    chk("full_cargando", 32'(dc[2]), 32'd0);
    chk("full_nivel", 32'(dn[2]), 32'b10000);

    // Refused draw on empty batteries.
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 1);
    settle;
    chk("empty_agotado", 32'(dg[0]), 32'd1);
    chk("empty_A", 32'(da[0]), 32'd0);
    cyc(0, 0, 0, 0);
    settle;
    chk("empty_agotado_end", 32'(dg[0]), 32'd0);

    // Step and draw on the same edge.
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    for (int k = 0; k < 3; k++) cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 1);
    settle;
    chk("both_A", 32'(da[1]), 32'd4);
    chk("both_B", 32'(db[1]), 32'd4);
    chk("both_Sum", 32'(ds[1]), 32'd8);
    chk("both_nivel", 32'(dn[1]), 32'b00010);
    chk("both_cargando", 32'(dc[1]), 32'd1);

    // Unplugging clears the prescaler.
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    for (int k = 0; k < 3; k++) cyc(0, 1, 1, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 0);
    settle;
    chk("presc_clr_A", 32'(da[0]), 32'd0);
    for (int k = 0; k < 3; k++) cyc(0, 1, 1, 0);
    settle;
    chk("presc_step_A", 32'(da[0]), 32'd1);

    // Reset wins mid-charge.
    for (int k = 0; k < 6; k++) cyc(0, 1, 1, 0);
    cyc(1, 1, 1, 1);
    settle;
    chk("rst_pri_A", 32'(da[0]), 32'd0);
    chk("rst_pri_cargando", 32'(dc[0]), 32'd0);
    chk("rst_pri_u1_B", 32'(db[1]), 32'd5);

    // Random phases: mostly charging, balanced, draining.
    for (int k = 0; k < 3000; k++) begin
      r = ($urandom_range(0, 299) == 0);
      e = ($urandom_range(0, 15) != 0);
      t = $urandom_range(0, 1) != 0;
      if (k < 1000)      c = ($urandom_range(0, 31) == 0);
      else if (k < 2000) c = ($urandom_range(0, 7) == 0);
      else               c = ($urandom_range(0, 2) == 0);
      cyc(r, e, t, c);
    end
    cyc(0, 0, 0, 0);

    repeat (4) @(posedge clk);
    #2;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
